// File: rtl/credit_pool_control_pkg.sv
// Shared definitions for the PSL command credit pool: class ordering,
// pool FSM states, arbitration mode selectors and a width helper.
package credit_pool_control_pkg;

    // Default upper bound on the loadable total credit count.
    localparam int CREDITS_MAX = 64;

    // Arbitration mode selectors.
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Command classes in priority order; index 0 is the highest priority.
    typedef enum logic [2:0] {
        CLS_RESTART  = 3'd0,
        CLS_WED      = 3'd1,
        CLS_WRITE    = 3'd2,
        CLS_PF_WRITE = 3'd3,
        CLS_READ     = 3'd4,
        CLS_PF_READ  = 3'd5
    } credit_class_t;

    // Pool lifecycle: IDLE until a valid total is loaded, ACTIVE while
    // granting, DRAIN while waiting for every outstanding credit to return.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } credit_pool_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/credit_pool_control_if.sv
// Command-side bus between the per-class command buffers (master) and the
// credit pool (slave): level requests, one-hot grants and credit returns.
interface credit_pool_control_if
    import credit_pool_control_pkg::*;
#(
    parameter int NUM_CLASSES = 6,
    localparam int IW = idx_width(NUM_CLASSES)
);
    logic [NUM_CLASSES-1:0] req;
    logic [NUM_CLASSES-1:0] grant;
    logic                   ret_valid;
    logic [IW-1:0]          ret_class;

    modport master (
        output req,
        output ret_valid,
        output ret_class,
        input  grant
    );

    modport slave (
        input  req,
        input  ret_valid,
        input  ret_class,
        output grant
    );
endinterface

// File: rtl/credit_pool_control_arbiter.sv
// Combinational one-hot picker over an eligibility vector. Fixed mode always
// searches from index 0; round-robin mode searches upward from ptr, wrapping.
module credit_class_arbiter
    import credit_pool_control_pkg::*;
#(
    parameter int NUM_CLASSES = 6,
    parameter int ARB_MODE    = ARB_FIXED,
    localparam int IW = idx_width(NUM_CLASSES)
) (
    input  logic [NUM_CLASSES-1:0] elig,
    input  logic [IW-1:0]          ptr,
    output logic [NUM_CLASSES-1:0] pick,
    output logic [IW-1:0]          pick_idx,
    output logic                   pick_valid
);
    localparam logic [IW:0] NUM_W = (IW+1)'(NUM_CLASSES);

    logic [IW-1:0] base;
    logic [IW:0]   cand;

    assign base = (ARB_MODE == ARB_RR) ? ptr : '0;

    // First eligible class walking upward from base, modulo NUM_CLASSES.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int off = 0; off < NUM_CLASSES; off++) begin
            cand = {1'b0, base} + (IW+1)'(off);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!pick_valid && elig[cand[IW-1:0]]) begin
                pick_valid             = 1'b1;
                pick_idx               = cand[IW-1:0];
                pick[cand[IW-1:0]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_pool_control.sv
// PSL command credit pool. Each class owns a guaranteed reserve; credits
// beyond the reserves form a shared pool borrowed on demand. At most one
// registered grant per cycle; returns are accounted in every state.
module credit_pool_control
    import credit_pool_control_pkg::*;
#(
    parameter int NUM_CLASSES        = 6,
    parameter int CREDITS_MAX        = credit_pool_control_pkg::CREDITS_MAX,
    parameter int RESERVED_PER_CLASS = 4,
    parameter int ARB_MODE           = ARB_FIXED,
    localparam int CW = $clog2(CREDITS_MAX + 1),
    localparam int IW = idx_width(NUM_CLASSES)
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic                    credits_load_valid,
    input  logic [CW-1:0]           credits_load_value,
    input  logic                    drain_req,
    credit_pool_control_if.slave    bus,
    output logic [CW-1:0]           credits_free,
    output logic [CW-1:0]           credits_inflight,
    output logic                    drained,
    output logic                    active,
    output logic [2:0]              error_flags
);
    localparam logic [CW-1:0] RES_SUM  = CW'(NUM_CLASSES * RESERVED_PER_CLASS);
    localparam logic [CW-1:0] RES_PER  = CW'(RESERVED_PER_CLASS);
    localparam logic [CW-1:0] T_MAX    = CW'(CREDITS_MAX);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);

    credit_pool_state_t     state_reg, state_next;
    logic [CW-1:0]          total_reg, total_next;
    logic [CW-1:0]          shared_used_reg, shared_used_next;
    logic [CW-1:0]          inflight_reg, inflight_next;
    logic [CW-1:0]          free_reg;
    logic [NUM_CLASSES-1:0] grant_reg;
    logic [IW-1:0]          ptr_reg;
    logic [2:0]             err_reg;

    logic [CW-1:0]          shared_total;
    logic                   shared_avail;
    logic                   grant_en;
    logic                   do_grant;
    logic                   ret_in_range;
    logic                   load_ok;
    logic                   load_err;
    logic [NUM_CLASSES-1:0] elig;
    logic [NUM_CLASSES-1:0] pick;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic [NUM_CLASSES-1:0] win_vec;
    logic [NUM_CLASSES-1:0] ret_ok_vec;
    logic [NUM_CLASSES-1:0] ret_bad_vec;
    logic [NUM_CLASSES-1:0] shared_inc;
    logic [NUM_CLASSES-1:0] shared_dec;

    assign shared_total = (total_reg >= RES_SUM) ? (total_reg - RES_SUM) : '0;
    assign shared_avail = (shared_used_reg < shared_total);
    assign grant_en     = (state_reg == ST_ACTIVE) && !drain_req;
    assign ret_in_range = (bus.ret_class <= LAST_IDX);
    assign load_ok      = (credits_load_value >= RES_SUM) && (credits_load_value <= T_MAX);

    credit_class_arbiter #(
        .NUM_CLASSES (NUM_CLASSES),
        .ARB_MODE    (ARB_MODE)
    ) u_arbiter (
        .elig       (elig),
        .ptr        (ptr_reg),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign win_vec  = grant_en ? pick : '0;
    assign do_grant = grant_en && pick_valid;

    // Per-class in-use counters. A grant and a valid return to the same
    // class in one cycle cancel, so neither the counter nor the shared
    // pool moves.
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : gen_class
            logic [CW-1:0] inuse_reg;
            logic          ret_hit;
            logic          ret_ok;
            logic          inc;
            logic          dec;

            assign ret_hit         = bus.ret_valid && ret_in_range && (bus.ret_class == IW'(gi));
            assign ret_ok          = ret_hit && (inuse_reg != '0);
            assign ret_ok_vec[gi]  = ret_ok;
            assign ret_bad_vec[gi] = ret_hit && (inuse_reg == '0);
            assign elig[gi]        = bus.req[gi] && ((inuse_reg < RES_PER) || shared_avail);
            assign inc             = win_vec[gi] && !ret_ok;
            assign dec             = ret_ok && !win_vec[gi];
            assign shared_inc[gi]  = inc && (inuse_reg >= RES_PER);
            assign shared_dec[gi]  = dec && (inuse_reg > RES_PER);

            // Count credits held by this class.
            always_ff @(posedge clock or negedge rstn) begin
                if (!rstn) begin
                    inuse_reg <= '0;
                end else if (inc) begin
                    inuse_reg <= inuse_reg + ONE;
                end else if (dec) begin
                    inuse_reg <= inuse_reg - ONE;
                end
            end
        end
    endgenerate

    // Pool-wide counters: at most one grant and one return per cycle.
    always_comb begin
        shared_used_next = shared_used_reg
                         + ((|shared_inc) ? ONE : '0)
                         - ((|shared_dec) ? ONE : '0);
        inflight_next    = inflight_reg
                         + (do_grant ? ONE : '0)
                         - ((|ret_ok_vec) ? ONE : '0);
    end

    // Next-state and total-credit decode for the pool lifecycle.
    always_comb begin
        state_next = state_reg;
        total_next = total_reg;
        load_err   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (credits_load_valid) begin
                    if (load_ok) begin
                        state_next = ST_ACTIVE;
                        total_next = credits_load_value;
                    end else begin
                        load_err = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (drain_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_reg == '0) begin
                    state_next = ST_IDLE;
                    total_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                total_next = '0;
            end
        endcase
    end

    // Register state, totals, grant, round-robin pointer and sticky errors.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_IDLE;
            total_reg       <= '0;
            shared_used_reg <= '0;
            inflight_reg    <= '0;
            free_reg        <= '0;
            grant_reg       <= '0;
            ptr_reg         <= '0;
            err_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            total_reg       <= total_next;
            shared_used_reg <= shared_used_next;
            inflight_reg    <= inflight_next;
            free_reg        <= total_next - inflight_next;
            grant_reg       <= win_vec;
            if ((ARB_MODE == ARB_RR) && do_grant) begin
                ptr_reg <= (pick_idx == LAST_IDX) ? '0 : (pick_idx + IW'(1));
            end
            err_reg <= err_reg | {bus.ret_valid && !ret_in_range, |ret_bad_vec, load_err};
        end
    end

    assign bus.grant        = grant_reg;
    assign credits_free     = free_reg;
    assign credits_inflight = inflight_reg;
    assign drained          = (state_reg == ST_DRAIN) && (inflight_reg == '0);
    assign active           = (state_reg == ST_ACTIVE);
    assign error_flags      = err_reg;

endmodule

// File: tb/tb_credit_pool_control.sv
// Directed bench for credit_pool_control: one fixed-priority and one
// round-robin instance driven with identical stimulus.
module tb_credit_pool_control;
    import credit_pool_control_pkg::*;

    localparam int NC = 6;
    localparam int CW = 7;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          rstn  = 1'b0;
    logic          load_valid;
    logic [CW-1:0] load_value;
    logic          drain_req;
    logic [NC-1:0] req;
    logic          ret_valid;
    logic [IW-1:0] ret_class;

    logic [CW-1:0] free_fp, inflight_fp, free_rr, inflight_rr;
    logic          drained_fp, active_fp, drained_rr, active_rr;
    logic [2:0]    err_fp, err_rr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    credit_pool_control_if #(.NUM_CLASSES(NC)) if_fp ();
    credit_pool_control_if #(.NUM_CLASSES(NC)) if_rr ();

    assign if_fp.req       = req;
    assign if_fp.ret_valid = ret_valid;
    assign if_fp.ret_class = ret_class;
    assign if_rr.req       = req;
    assign if_rr.ret_valid = ret_valid;
    assign if_rr.ret_class = ret_class;

    credit_pool_control #(.NUM_CLASSES(NC), .CREDITS_MAX(64), .RESERVED_PER_CLASS(4), .ARB_MODE(ARB_FIXED)) u_dut_fp (
        .clock              (clock),
        .rstn               (rstn),
        .credits_load_valid (load_valid),
        .credits_load_value (load_value),
        .drain_req          (drain_req),
        .bus                (if_fp),
        .credits_free       (free_fp),
        .credits_inflight   (inflight_fp),
        .drained            (drained_fp),
        .active             (active_fp),
        .error_flags        (err_fp)
    );

    credit_pool_control #(.NUM_CLASSES(NC), .CREDITS_MAX(64), .RESERVED_PER_CLASS(4), .ARB_MODE(ARB_RR)) u_dut_rr (
        .clock              (clock),
        .rstn               (rstn),
        .credits_load_valid (load_valid),
        .credits_load_value (load_value),
        .drain_req          (drain_req),
        .bus                (if_rr),
        .credits_free       (free_rr),
        .credits_inflight   (inflight_rr),
        .drained            (drained_rr),
        .active             (active_rr),
        .error_flags        (err_rr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        drain_req  = 1'b0;
        req        = '0;
        ret_valid  = 1'b0;
        ret_class  = '0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic load(input int t);
        load_valid = 1'b1;
        load_value = CW'(t);
        tick();
        load_valid = 1'b0;
    endtask

    // Ticks n cycles, counting cycles where the fixed-mode grant equals mask.
    task automatic count_grants(input int n, input logic [NC-1:0] mask, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (if_fp.grant == mask) cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [NC-1:0] m_read;
        m_read = NC'(1) << CLS_READ;

        // Reset values
        do_reset();
        rstn = 1'b0;
        tick();
        check("rst_grant", if_fp.grant, 0);
        check("rst_free", free_fp, 0);
        check("rst_inflight", inflight_fp, 0);
        check("rst_drained", drained_fp, 0);
        check("rst_active", active_fp, 0);
        check("rst_err", err_fp, 0);
        rstn = 1'b1;
        tick();

        // Full load, then one class exhausts reserve plus shared pool
        load(64);
        check("load64_active", active_fp, 1);
        check("load64_free", free_fp, 64);
        check("load64_err", err_fp, 0);
        req = m_read;
        count_grants(50, m_read, n);
        check("read_only_grants", n, 44);
        check("read_only_idle_grant", if_fp.grant, 0);
        check("read_only_inflight", inflight_fp, 44);
        check("read_only_free", free_fp, 20);
        req = NC'(1);
        count_grants(8, NC'(1), n);
        check("restart_reserve_grants", n, 4);
        check("restart_inflight", inflight_fp, 48);
        check("restart_free", free_fp, 16);
        req = '0;

        // Invalid and boundary loads
        do_reset();
        load(20);
        check("load20_err", err_fp, 1);
        check("load20_active", active_fp, 0);
        load(65);
        check("load65_active", active_fp, 0);
        load(24);
        check("load24_active", active_fp, 1);
        check("load24_free", free_fp, 24);
        check("load24_err_sticky", err_fp, 1);
        req = m_read;
        count_grants(8, m_read, n);
        check("load24_no_shared_grants", n, 4);
        req = '0;

        // Arbitration: round-robin rotates, fixed priority sticks to class 0
        do_reset();
        load(64);
        req = '1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("rr_grant_%0d", k), if_rr.grant, 32'(NC'(1) << (k % NC)));
            check($sformatf("fp_grant_%0d", k), if_fp.grant, 1);
        end
        req = '0;

        // Same-cycle grant and return, underflow and out-of-range returns
        do_reset();
        load(64);
        req = NC'(1) << 2;
        count_grants(5, NC'(1) << 2, n);
        check("cls2_grants", n, 5);
        ret_valid = 1'b1;
        ret_class = IW'(2);
        tick();
        check("same_cls_grant", if_fp.grant, 4);
        check("same_cls_inflight", inflight_fp, 5);
        ret_valid = 1'b0;
        count_grants(45, NC'(1) << 2, n);
        check("cls2_shared_left", n, 39);
        check("cls2_inflight", inflight_fp, 44);
        check("cls2_free", free_fp, 20);
        req = '0;
        ret_valid = 1'b1;
        ret_class = IW'(3);
        tick();
        check("underflow_err", err_fp, 2);
        check("underflow_inflight", inflight_fp, 44);
        ret_class = IW'(7);
        tick();
        check("bad_class_err", err_fp, 6);
        check("bad_class_inflight", inflight_fp, 44);
        ret_class = IW'(2);
        tick();
        check("ret2_inflight", inflight_fp, 43);
        check("ret2_free", free_fp, 21);
        req = NC'(1);
        tick();
        check("diff_cls_grant", if_fp.grant, 1);
        check("diff_cls_inflight", inflight_fp, 43);
        ret_valid = 1'b0;
        req = '0;
        tick();

        // Drain with 10 credits outstanding
        do_reset();
        load(64);
        req = NC'(1) << 1;
        count_grants(10, NC'(1) << 1, n);
        check("drain_setup_grants", n, 10);
        req = '0;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        check("drain_active", active_fp, 0);
        check("drain_inflight", inflight_fp, 10);
        req = NC'(1) << 1;
        count_grants(3, '0, n);
        check("drain_no_grants", n, 3);
        ret_valid = 1'b1;
        ret_class = IW'(1);
        repeat (9) tick();
        check("drain_9_inflight", inflight_fp, 1);
        check("drain_9_drained", drained_fp, 0);
        tick();
        ret_valid = 1'b0;
        check("drain_10_drained", drained_fp, 1);
        check("drain_10_inflight", inflight_fp, 0);
        tick();
        check("idle_drained", drained_fp, 0);
        check("idle_active", active_fp, 0);
        check("idle_free", free_fp, 0);
        check("idle_grant", if_fp.grant, 0);
        check("idle_err", err_fp, 0);
        req = '0;
        load(64);
        check("reload_active", active_fp, 1);

        // Asynchronous reset in the middle of a drain
        req = NC'(1) << 1;
        count_grants(3, NC'(1) << 1, n);
        check("mid_grants", n, 3);
        req = '0;
        ret_valid = 1'b1;
        ret_class = IW'(7);
        tick();
        ret_valid = 1'b0;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        check("mid_drain_inflight", inflight_fp, 3);
        check("mid_drain_err", err_fp, 4);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_grant", if_fp.grant, 0);
        check("async_rst_free", free_fp, 0);
        check("async_rst_inflight", inflight_fp, 0);
        check("async_rst_drained", drained_fp, 0);
        check("async_rst_active", active_fp, 0);
        check("async_rst_err", err_fp, 0);
        tick();
        rstn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/credit_pool_control.md
Name: credit_pool_control

Overview:
- Parametrised successor to the fixed 32-read/32-write credit split; manages the PSL command credit budget across NUM_CLASSES command classes (restart, wed, write, prefetch write, read, prefetch read).
- Each class gets a guaranteed reserve; the remainder forms a shared pool borrowed on demand.
- Total credits are loaded at run time, and arbitration mode is selectable.
- Sits in AFU-Control between the per-class command buffers and the PSL command interface.

Parameters:
NUM_CLASSES, 6, number of command classes; index 0 = highest priority
CREDITS_MAX, 64, upper bound on loadable total credits
RESERVED_PER_CLASS, 4, credits guaranteed to each class
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clock  in  1  clock
rstn  in  1  asynchronous active-low reset
credits_load_valid  in  1  load total credit count (accepted only in IDLE)
credits_load_value  in  $clog2(CREDITS_MAX+1)  total credits T
req  in  NUM_CLASSES  level request per class (pending command)
ret_valid  in  1  one credit returned this cycle
ret_class  in  $clog2(NUM_CLASSES)  class of returned credit
drain_req  in  1  stop granting, wait for all credits back
grant  out  NUM_CLASSES  one-hot (or zero) registered grant
credits_free  out  $clog2(CREDITS_MAX+1)  T minus credits in flight
credits_inflight  out  $clog2(CREDITS_MAX+1)  total credits outstanding
drained  out  1  DRAIN state with credits_inflight = 0
active  out  1  state = ACTIVE
error_flags  out  3  sticky: [0] bad load, [1] return underflow, [2] bad ret_class

Behaviour:
- Reset: state IDLE; grant=0; all counters 0; credits_free=0; credits_inflight=0; drained=0; active=0; error_flags=0; round-robin pointer=0.
- States:
  - IDLE->ACTIVE on credits_load_valid with T >= NUM_CLASSES*RESERVED_PER_CLASS and T <= CREDITS_MAX. Latch T; shared_total = T - NUM_CLASSES*RESERVED_PER_CLASS.
  - On an invalid load: set error_flags[0] and remain in IDLE.
  - ACTIVE->DRAIN on drain_req.
  - DRAIN->IDLE one cycle after drained is asserted; T is cleared on entry to IDLE.
  - drain_req in IDLE is ignored.
- Eligibility of class i: req[i] and (inuse[i] < RESERVED_PER_CLASS or shared_used < shared_total).
- Grants occur only in ACTIVE, at most one per cycle.
  - Winner is chosen from req and counters sampled at edge N; grant is high during cycle N+1 only.
  - Counters update at edge N.
  - req still high during a grant cycle counts as a further request.
- ARB_MODE 1: the search starts at the pointer; after a grant to class k, the pointer becomes (k+1) mod NUM_CLASSES. No class waits more than NUM_CLASSES-1 grants while eligible.
- Grant accounting: inuse[i]++; if pre-grant inuse[i] >= RESERVED_PER_CLASS, then shared_used++.
- Return accounting, class c: if inuse[c] = 0, set error_flags[1] and leave counters unchanged. Otherwise inuse[c]--, and if pre-return inuse[c] > RESERVED_PER_CLASS, shared_used--.
- ret_class >= NUM_CLASSES: set error_flags[2] and ignore the return.
- Returns are processed in every state, including IDLE (stale credits).
- Same-cycle grant and return to the same class: inuse and shared_used are unchanged.
- Same-cycle grant and return to different classes: both are applied independently.
- credits_inflight = sum of inuse, maintained incrementally (+grant, -valid return). credits_free = T - credits_inflight. Both are registered and consistent with the counters after each edge.
- Reset mid-operation: everything returns to reset values; in-flight credits are forgotten, so software must reload.
- error_flags clear only on reset.

Decomposition:
- Shared package (GLOBALS_AFU_PKG):
  - CREDITS_MAX
  - credit_class_t enum mirroring the PRIORITY_* ordering
  - credit_pool_state_t {IDLE, ACTIVE, DRAIN}
  - ARB_FIXED/ARB_RR constants
- Sub-module credit_class_arbiter: combinational fixed/round-robin one-hot picker taking an eligibility vector and pointer; reusable by other arbiters.

Test Plan:
- Load T=64 (NUM_CLASSES=6, R=4) -> active=1, shared_total=40, credits_free=64.
- Load T=20 -> error_flags[0]=1, active=0.
- Only class 4 requests continuously, no returns -> exactly 44 grants (4 reserve + 40 shared), then grant=0. Class 0 then requests -> granted 4 times despite shared pool exhausted.
- ARB_MODE 1, all 6 classes request -> grants rotate 0,1,2,3,4,5,0, one per cycle. ARB_MODE 0, same stimulus -> class 0 granted every cycle.
- Class 2 holds inuse=5; same-cycle grant to class 2 and return of class 2 -> inuse stays 5, shared_used unchanged. Return for a class with inuse=0 -> error_flags[1]=1, counters unchanged.
- 10 credits in flight, drain_req -> no further grants; drained=1 after the 10th return; IDLE next cycle; asserting rstn low mid-drain -> all outputs at reset values.
